// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stack-unit operation encoding and FSM state type.
package cpu_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } stk_state_t;

    // PUSH and CALL write the stack; POP and RET read it.
    function automatic logic op_is_write(input logic [1:0] op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/call_stack_unit_if.sv
// Request/response bus between the controller and the call stack unit.
interface call_stack_unit_if #(
    parameter int DATA_W = 16,
    parameter int PTR_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [PTR_W:0]    count;
    logic              full;
    logic              empty;

    modport master (
        output req_valid, req_op, req_data, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, count, full, empty
    );

    modport slave (
        input  req_valid, req_op, req_data, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, count, full, empty
    );
endinterface

// File: rtl/stack_ram.sv
// Single-port register array: synchronous write, combinational read.
module stack_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) mem[addr] <= wr_data;
    end

    assign rd_data = mem[addr];
endmodule

// File: rtl/call_stack_unit.sv
// Hardware call stack: PUSH/POP/CALL/RET over a valid/ready bus, three-state FSM.
module call_stack_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input logic         clock,
    input logic         reset,
    call_stack_unit_if.slave bus
);
    localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    stk_state_t        state;
    logic              req_ready_r, rsp_valid_r, rsp_err_r, full_r, empty_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic [PTR_W:0]    count_r, count_nxt;

    logic [1:0]        op_r;
    logic [DATA_W-1:0] data_r, pc_r;

    logic              is_write, wr_en, op_err;
    logic [PTR_W-1:0]  addr;
    logic [DATA_W-1:0] wr_data, rd_data, op_data;

    // Request fields are held for the EXEC cycle; they need no reset.
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && bus.req_valid) begin
            op_r   <= bus.req_op;
            data_r <= bus.req_data;
            pc_r   <= bus.req_pc;
        end
    end

    assign is_write = op_is_write(op_r);
    // Writes go to the free slot at count; reads come from the top entry at count-1.
    assign addr     = is_write ? count_r[PTR_W-1:0] : count_r[PTR_W-1:0] - PTR_ONE;
    assign wr_data  = (op_r == OP_CALL) ? pc_r + DATA_W'(1) : data_r;

    always_comb begin
        wr_en     = 1'b0;
        op_err    = 1'b0;
        op_data   = '0;
        count_nxt = count_r;
        if (is_write) begin
            if (count_r == FULL_CNT) begin
                op_err = 1'b1;
            end else begin
                wr_en     = (state == ST_EXEC);
                count_nxt = count_r + CNT_ONE;
                op_data   = data_r;
            end
        end else begin
            if (count_r == '0) begin
                op_err = 1'b1;
            end else begin
                count_nxt = count_r - CNT_ONE;
                op_data   = rd_data;
            end
        end
    end

    stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            count_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        state       <= ST_EXEC;
                        req_ready_r <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    state       <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_data_r  <= op_data;
                    rsp_err_r   <= op_err;
                    count_r     <= count_nxt;
                    full_r      <= (count_nxt == FULL_CNT);
                    empty_r     <= (count_nxt == '0);
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.count     = count_r;
    assign bus.full      = full_r;
    assign bus.empty     = empty_r;
endmodule
